// File: rtl/ras_multithread_if.sv
// ras_multithread_if: RAS request/status bundle; master drives thread/push/pop/flush, slave returns top-of-stack and status
interface ras_multithread_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH         = 16,
  parameter int THREAD_BITS   = 2
);
  logic                       i_push;
  logic                       i_pop;
  logic                       i_flush;
  logic [THREAD_BITS-1:0]     i_thread;
  logic [THREAD_BITS-1:0]     i_flush_thread;
  logic [ADDRESS_WIDTH-1:0]   i_address;
  logic [ADDRESS_WIDTH-1:0]   o_address;
  logic                       o_valid;
  logic                       o_full;
  logic [$clog2(DEPTH):0]     o_count;
  logic                       o_overflow;
  logic                       o_underflow;
  modport master (
    output i_push, i_pop, i_flush, i_thread, i_flush_thread, i_address,
    input  o_address, o_valid, o_full, o_count, o_overflow, o_underflow
  );
  modport slave (
    input  i_push, i_pop, i_flush, i_thread, i_flush_thread, i_address,
    output o_address, o_valid, o_full, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/ras_multithread.sv
// ras_multithread: per-thread circular return-address stack; ports: i_Clk, i_Reset_n (async low), bus (slave: push/pop/flush in, top/valid/full/count/pulses out)
module ras_multithread #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH         = 16,
  parameter int NUM_THREADS   = 4,
  parameter int THREAD_BITS   = 2
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  ras_multithread_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDRESS_WIDTH-1:0] mem_q [NUM_THREADS][DEPTH];
  logic [PW-1:0] tos_q [NUM_THREADS];
  logic [PW-1:0] tos_d [NUM_THREADS];
  logic [CW-1:0] cnt_q [NUM_THREADS];
  logic [CW-1:0] cnt_d [NUM_THREADS];
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic sel_ok, act, empty, full, do_push, do_rep, do_pop;
  logic [PW-1:0] tos_sel, wa;
  logic [CW-1:0] cnt_sel;
  assign sel_ok  = int'(bus.i_thread) < NUM_THREADS;
  assign tos_sel = sel_ok ? tos_q[bus.i_thread] : '0;
  assign cnt_sel = sel_ok ? cnt_q[bus.i_thread] : '0;
  assign empty   = cnt_sel == '0;
  assign full    = cnt_sel == CW'(DEPTH);
  // a flush of the selected thread cancels its operation entirely
  assign act     = sel_ok && !(bus.i_flush && bus.i_flush_thread == bus.i_thread);
  // push+pop on a non-empty stack replaces the top; on an empty stack it degrades to a plain push
  assign do_rep  = act && bus.i_push && bus.i_pop && !empty;
  assign do_push = act && bus.i_push && !do_rep;
  assign do_pop  = act && bus.i_pop && !bus.i_push && !empty;
  assign wa      = do_rep ? tos_sel : tos_sel + PW'(1);
  assign ovf_d   = do_push && full;
  assign unf_d   = act && bus.i_pop && !bus.i_push && empty;
  assign bus.o_count     = cnt_sel;
  assign bus.o_valid     = !empty;
  assign bus.o_full      = full;
  assign bus.o_address   = empty ? '0 : mem_q[bus.i_thread][tos_sel];
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = unf_q;
  always_comb begin
    tos_d = tos_q;
    cnt_d = cnt_q;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (THREAD_BITS'(t) == bus.i_thread) begin
        tos_d[t] = do_push ? wa : do_pop ? tos_sel - PW'(1) : tos_q[t];
        cnt_d[t] = (do_push && !full) ? cnt_q[t] + CW'(1) : do_pop ? cnt_q[t] - CW'(1) : cnt_q[t];
      end
      if (bus.i_flush && THREAD_BITS'(t) == bus.i_flush_thread) begin
        tos_d[t] = '0;
        cnt_d[t] = '0;
      end
    end
  end
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      tos_q <= '{default: '0};
      cnt_q <= '{default: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge i_Clk) begin
    if (do_push || do_rep) mem_q[bus.i_thread][wa] <= bus.i_address;
  end
endmodule

// File: tb/tb_ras_multithread.sv
// tb_ras_multithread: queue-based stack model with per-cycle compare, directed literal checks and random traffic
module tb_ras_multithread;
  localparam int AW = 22, D = 16, NT = 4, TB = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ras_multithread_if #(.ADDRESS_WIDTH(AW), .DEPTH(D), .THREAD_BITS(TB)) bus ();
  ras_multithread #(.ADDRESS_WIDTH(AW), .DEPTH(D), .NUM_THREADS(NT), .THREAD_BITS(TB)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .bus(bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [AW-1:0] stk [NT][$];
  logic e_ovf = 1'b0;
  logic e_unf = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: each thread is a bounded queue; overflow drops the oldest entry
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NT; t++) stk[t].delete();
      e_ovf <= 1'b0;
      e_unf <= 1'b0;
    end else begin
      e_ovf <= 1'b0;
      e_unf <= 1'b0;
      if (!(bus.i_flush && bus.i_flush_thread == bus.i_thread) && int'(bus.i_thread) < NT) begin
        if (bus.i_push && bus.i_pop && stk[bus.i_thread].size() > 0) begin
          void'(stk[bus.i_thread].pop_back());
          stk[bus.i_thread].push_back(bus.i_address);
        end else if (bus.i_push) begin
          stk[bus.i_thread].push_back(bus.i_address);
          if (stk[bus.i_thread].size() > D) begin
            void'(stk[bus.i_thread].pop_front());
            e_ovf <= 1'b1;
          end
        end else if (bus.i_pop) begin
          if (stk[bus.i_thread].size() > 0) void'(stk[bus.i_thread].pop_back());
          else e_unf <= 1'b1;
        end
      end
      if (bus.i_flush) stk[bus.i_flush_thread].delete();
    end
  end
  always @(negedge clk) begin
    chk("m_count", 32'(bus.o_count), 32'(stk[bus.i_thread].size()));
    chk("m_top", 32'(bus.o_address), stk[bus.i_thread].size() > 0 ? 32'(stk[bus.i_thread][$]) : 32'd0);
    chk("m_valid", 32'(bus.o_valid), 32'(stk[bus.i_thread].size() > 0));
    chk("m_full", 32'(bus.o_full), 32'(stk[bus.i_thread].size() == D));
    chk("m_ovf", 32'(bus.o_overflow), 32'(e_ovf));
    chk("m_unf", 32'(bus.o_underflow), 32'(e_unf));
  end
  task automatic set(input logic [TB-1:0] t, input logic ps, input logic pp, input logic [AW-1:0] a,
                     input logic fl, input logic [TB-1:0] ft);
    bus.i_thread = t;
    bus.i_push = ps;
    bus.i_pop = pp;
    bus.i_address = a;
    bus.i_flush = fl;
    bus.i_flush_thread = ft;
  endtask
  task automatic go();
    @(posedge clk);
    #2;
  endtask
  task automatic op(input logic [TB-1:0] t, input logic ps, input logic pp, input logic [AW-1:0] a);
    set(t, ps, pp, a, 1'b0, '0);
    go();
  endtask
  task automatic sel(input logic [TB-1:0] t);
    set(t, 1'b0, 1'b0, '0, 1'b0, '0);
    #1;
  endtask
  initial begin
    set('0, 1'b0, 1'b0, '0, 1'b0, '0);
    go();
    go();
    sel(0);
    chk("rst_count", 32'(bus.o_count), 0);
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_full", 32'(bus.o_full), 0);
    chk("rst_addr", 32'(bus.o_address), 0);
    chk("rst_ovf", 32'(bus.o_overflow), 0);
    chk("rst_unf", 32'(bus.o_underflow), 0);
    rst_n = 1'b1;
    go();
    op(0, 1, 0, 'h100);
    op(0, 1, 0, 'h200);
    op(0, 1, 0, 'h300);
    sel(0);
    chk("t0_count3", 32'(bus.o_count), 3);
    chk("t0_top300", 32'(bus.o_address), 'h300);
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 1, '0, 0, '0);
      #1;
      chk("t0_pop_target", 32'(bus.o_address), 32'('h300 - i * 'h100));
      go();
    end
    sel(0);
    chk("t0_empty_valid", 32'(bus.o_valid), 0);
    chk("t0_empty_addr", 32'(bus.o_address), 0);
    for (int i = 1; i <= D + 2; i++) begin
      op(2, 1, 0, AW'(i));
      chk("t2_ovf_pulse", 32'(bus.o_overflow), 32'(i > D));
    end
    sel(2);
    chk("t2_full", 32'(bus.o_full), 1);
    chk("t2_count16", 32'(bus.o_count), D);
    for (int i = 0; i < D; i++) begin
      set(2, 0, 1, '0, 0, '0);
      #1;
      chk("t2_pop_target", 32'(bus.o_address), 32'(D + 2 - i));
      go();
    end
    op(2, 0, 1, '0);
    chk("t2_unf_pulse", 32'(bus.o_underflow), 1);
    chk("t2_unf_count", 32'(bus.o_count), 0);
    op(2, 0, 0, '0);
    chk("t2_unf_clear", 32'(bus.o_underflow), 0);
    op(1, 1, 0, 'hA);
    op(3, 1, 0, 'hB);
    sel(1);
    chk("t1_top_A", 32'(bus.o_address), 'hA);
    sel(3);
    chk("t3_top_B", 32'(bus.o_address), 'hB);
    op(1, 0, 1, '0);
    sel(3);
    chk("t3_count_kept", 32'(bus.o_count), 1);
    chk("t3_top_kept", 32'(bus.o_address), 'hB);
    op(0, 1, 0, 'h10);
    op(0, 1, 0, 'h20);
    op(0, 1, 1, 'h30);
    sel(0);
    chk("rep_count", 32'(bus.o_count), 2);
    chk("rep_top", 32'(bus.o_address), 'h30);
    op(0, 0, 1, '0);
    sel(0);
    chk("rep_pop_top", 32'(bus.o_address), 'h10);
    op(1, 1, 1, 'h55);
    chk("rep_empty_unf", 32'(bus.o_underflow), 0);
    sel(1);
    chk("rep_empty_count", 32'(bus.o_count), 1);
    chk("rep_empty_top", 32'(bus.o_address), 'h55);
    for (int i = 1; i <= 4; i++) op(0, 1, 0, AW'('h10 + i));
    sel(0);
    chk("t0_count5", 32'(bus.o_count), 5);
    set(0, 1, 0, 'h99, 1, 0);
    go();
    chk("flush_same_count", 32'(bus.o_count), 0);
    chk("flush_same_ovf", 32'(bus.o_overflow), 0);
    chk("flush_same_unf", 32'(bus.o_underflow), 0);
    set(0, 1, 0, 'h42, 1, 1);
    go();
    sel(0);
    chk("flush_other_count", 32'(bus.o_count), 1);
    chk("flush_other_top", 32'(bus.o_address), 'h42);
    sel(1);
    chk("flush_other_t1", 32'(bus.o_count), 0);
    op(0, 1, 0, 'h61);
    op(0, 1, 0, 'h62);
    set(0, 1, 0, 'h63, 0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.o_count), 0);
    chk("arst_valid", 32'(bus.o_valid), 0);
    chk("arst_addr", 32'(bus.o_address), 0);
    sel(3);
    chk("arst_t3_count", 32'(bus.o_count), 0);
    set(0, 1, 0, 'h63, 0, '0);
    go();
    chk("arst_hold_count", 32'(bus.o_count), 0);
    rst_n = 1'b1;
    op(0, 1, 0, 'h77);
    sel(0);
    chk("post_rst_count", 32'(bus.o_count), 1);
    chk("post_rst_top", 32'(bus.o_address), 'h77);
    for (int c = 0; c < 3000; c++) begin
      bit heavy;
      heavy = ((c / 150) % 2) == 0;
      set(TB'($urandom_range(0, NT - 1)),
          $urandom_range(0, 99) < (heavy ? 75 : 30),
          $urandom_range(0, 99) < (heavy ? 20 : 60),
          AW'($urandom),
          $urandom_range(0, 99) < 4,
          TB'($urandom_range(0, NT - 1)));
      go();
    end
    sel(0);
    go();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ras_multithread.md
Name: ras_multithread

Overview:
- Per-thread return-address stack (RAS) for the fetch/pre-align stage of the multithreaded MIPS core.
- Generalises the fixed 4-thread jump stack: parametrised thread count and depth, circular overwrite on overflow, and underflow protection.
- Adds a combined push+pop (replace-top) operation, per-thread flush, and status outputs.
- jal pushes the return address; jr pops and supplies the predicted target.

Parameters:
- ADDRESS_WIDTH, 22, width of stored return address.
- DEPTH, 16, entries per thread stack; power of 2, >= 2.
- NUM_THREADS, 4, number of hardware threads; >= 2.
- THREAD_BITS, 2, width of thread selectors; equals clog2(NUM_THREADS).

Ports:
- i_Clk  in  1  clock; all state updates on rising edge.
- i_Reset_n  in  1  asynchronous active-low reset.
- i_thread  in  THREAD_BITS  thread selected for the push/pop and for all outputs.
- i_push  in  1  push i_address onto the i_thread stack (jal).
- i_pop  in  1  pop the i_thread stack (jr).
- i_address  in  ADDRESS_WIDTH  return address to push.
- i_flush  in  1  clear the stack of i_flush_thread (mispredict/thread kill).
- i_flush_thread  in  THREAD_BITS  thread to flush.
- o_address  out  ADDRESS_WIDTH  top-of-stack of i_thread; 0 when that stack is empty.
- o_valid  out  1  i_thread stack non-empty.
- o_full  out  1  i_thread stack holds DEPTH entries.
- o_count  out  clog2(DEPTH)+1  entry count of i_thread.
- o_overflow  out  1  registered one-cycle pulse: previous push overwrote the oldest entry.
- o_underflow  out  1  registered one-cycle pulse: previous pop hit an empty stack.

Behaviour:
- Per-thread state: circular buffer mem[DEPTH], tos pointer (clog2(DEPTH) bits), count (0..DEPTH).
- Reset (async, any time, including mid-operation):
  - all tos = 0, all count = 0.
  - o_overflow = 0, o_underflow = 0.
  - o_valid = 0, o_full = 0, o_count = 0, o_address = 0.
  - mem contents not reset.
- Outputs o_address/o_valid/o_full/o_count are combinational from the current state of i_thread.
  - Zero-latency read: a pop's target is visible in the same cycle i_pop is asserted.
- Operations apply only to i_thread at the rising edge (i_thread out of range: no-op):
  - push only: tos <= tos+1 (mod DEPTH); mem[tos+1] <= i_address; count <= min(count+1, DEPTH).
    - If count == DEPTH before the push, the oldest entry is overwritten and o_overflow pulses next cycle.
  - pop only, count > 0: tos <= tos-1 (mod DEPTH); count <= count-1.
  - pop only, count == 0: state unchanged; o_underflow pulses next cycle.
  - push and pop together, count > 0: mem[tos] <= i_address; tos and count unchanged (replace top; jr followed by jal in the same bundle).
  - push and pop together, count == 0: treated as push only; no underflow pulse.
  - neither: no change.
- Flush: i_flush sets tos = 0, count = 0 for i_flush_thread on the edge.
  - Flush and op on the same thread: flush wins; op discarded; no overflow/underflow pulses.
  - Flush and op on different threads: both take effect.
- Pulses are asserted for exactly one cycle after the causing edge, otherwise 0. Other threads never affect the selected thread's state.
- Wrap-around: the tos pointer wraps modulo DEPTH; count saturates at DEPTH and never exceeds it.

Test Plan:
- Reset, then thread 0: push 0x000100, 0x000200, 0x000300 -> o_count=3, o_address=0x000300; three pops return 0x000300, 0x000200, 0x000100 in order; then o_valid=0, o_address=0.
- Thread 2: push DEPTH+2 (18) values 1..18 -> o_overflow pulses on the 17th and 18th pushes; o_full=1, o_count=16; 16 pops return 18 down to 3; 17th pop -> o_underflow pulse, count stays 0.
- Interleave: push 0xA to thread 1 and 0xB to thread 3; select thread 1 -> 0xA, select thread 3 -> 0xB; pop thread 1 -> thread 3 still count=1, top 0xB.
- Thread 0 holding [0x10, 0x20]: push+pop with 0x30 -> count=2, top 0x30; pop -> 0x10 on top; push+pop on the empty thread 1 -> count=1, top = pushed value.
- Thread 0 count=5: flush thread 0 together with a push to thread 0 -> count=0, no pulses; flush thread 1 together with a push to thread 0 -> thread 0 count increments.
- Assert i_Reset_n low mid-sequence with pushes pending -> all counts 0 and outputs 0 immediately, asynchronously; first push after release yields count=1.
